// File: rtl/sel_seq_pkg.sv
// Shared types and defaults for the select-code sequencer that feeds the one-hot decoder.
package sel_seq_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic MODE_ONESHOT = 1'b0;
  localparam logic MODE_CONT    = 1'b1;

  localparam int SEL_W_DEF   = 2;
  localparam int DWELL_W_DEF = 8;

endpackage

// File: rtl/dwell_counter.sv
// Per-channel dwell counter: counts enabled cycles and flags the last cycle of a dwell.
module dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               enable,
  input  logic [DWELL_W-1:0] limit,
  output logic               expire
);

  logic [DWELL_W-1:0] cnt_q, cnt_d;

  // limit is never zero, so limit-1 cannot underflow
  assign expire = enable && (cnt_q == (limit - DWELL_W'(1)));

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (enable) begin
      cnt_d = expire ? '0 : cnt_q + DWELL_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/sel_sequencer.sv
// Sweeps a registered select code across all channels with a programmable dwell,
// in one-shot or continuous mode, with pause and abort.
module sel_sequencer
  import sel_seq_pkg::*;
#(
  parameter int SEL_W   = SEL_W_DEF,
  parameter int DWELL_W = DWELL_W_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop,
  input  logic               pause,
  input  logic               mode,
  input  logic [DWELL_W-1:0] dwell,
  output logic [SEL_W-1:0]   tbit,
  output logic               valid,
  output logic               busy,
  output logic               sweep_done
);

  localparam int              N_CH    = 2 ** SEL_W;
  localparam logic [SEL_W-1:0] LAST_CH = SEL_W'(N_CH - 1);

  state_t             state_q, state_d;
  logic               mode_q, mode_d;
  logic [DWELL_W-1:0] dwell_q, dwell_d;
  logic [SEL_W-1:0]   tbit_q, tbit_d;
  logic               sweep_done_q, sweep_done_d;
  logic               cnt_clear, cnt_en, expire;

  dwell_counter #(
    .DWELL_W (DWELL_W)
  ) u_dwell_counter (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (cnt_clear),
    .enable (cnt_en),
    .limit  (dwell_q),
    .expire (expire)
  );

  always_comb begin
    state_d      = state_q;
    mode_d       = mode_q;
    dwell_d      = dwell_q;
    tbit_d       = tbit_q;
    sweep_done_d = 1'b0;
    cnt_clear    = 1'b0;
    cnt_en       = 1'b0;
    case (state_q)
      IDLE: begin
        tbit_d = '0;
        if (start && !stop) begin
          mode_d    = mode;
          dwell_d   = (dwell == '0) ? DWELL_W'(1) : dwell;
          cnt_clear = 1'b1;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (stop) begin
          state_d   = IDLE;
          tbit_d    = '0;
          cnt_clear = 1'b1;
        end else if (!pause) begin
          cnt_en = 1'b1;
          if (expire) begin
            if (tbit_q == LAST_CH) begin
              // sweep_done lands on the first cycle showing channel 0 (or the first IDLE cycle)
              tbit_d       = '0;
              sweep_done_d = 1'b1;
              if (mode_q == MODE_ONESHOT) begin
                state_d = IDLE;
              end
            end else begin
              tbit_d = tbit_q + SEL_W'(1);
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        tbit_d  = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mode_q       <= MODE_ONESHOT;
      dwell_q      <= DWELL_W'(1);
      tbit_q       <= '0;
      sweep_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      dwell_q      <= dwell_d;
      tbit_q       <= tbit_d;
      sweep_done_q <= sweep_done_d;
    end
  end

  assign tbit       = tbit_q;
  assign valid      = (state_q == RUN);
  assign busy       = (state_q == RUN);
  assign sweep_done = sweep_done_q;

endmodule

// File: tb/tb_sel_sequencer.sv
// Directed self-checking bench for sel_sequencer, including a downstream one-hot decode check.
module tb_sel_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, stop, pause, mode;
  logic [7:0] dwell;
  logic [1:0] tbit;
  logic       valid, busy, sweep_done;
  logic [3:0] fbit;

  int checks = 0;
  int errors = 0;

  logic [3:0] onehot_tbl [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

  always #5 clk = ~clk;

  assign fbit = 4'b0001 << tbit;

  sel_sequencer #(.SEL_W(2), .DWELL_W(8)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .mode       (mode),
    .dwell      (dwell),
    .tbit       (tbit),
    .valid      (valid),
    .busy       (busy),
    .sweep_done (sweep_done)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1; stop = 1'b0; pause = 1'b0; mode = 1'b0; dwell = 8'd3;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({tbit, valid, busy, sweep_done} !== 5'b00_000) begin
        errors++;
        $display("FAIL reset cyc %0d: tbit=%0d valid=%b busy=%b done=%b, want 0 0 0 0",
                 i, tbit, valid, busy, sweep_done);
      end
    end
    rst_n = 1'b1; start = 1'b0;
    step();
    $display("reset: done");
  endtask

  task automatic test_oneshot();
    mode = 1'b0; dwell = 8'd3; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      logic [1:0] exp_t;
      exp_t = 2'(i / 3);
      checks++;
      if (tbit !== exp_t || valid !== 1'b1 || busy !== 1'b1 || sweep_done !== 1'b0) begin
        errors++;
        $display("FAIL oneshot cyc %0d: tbit=%0d valid=%b busy=%b done=%b, want %0d 1 1 0",
                 i, tbit, valid, busy, sweep_done, exp_t);
      end
      checks++;
      if (fbit !== onehot_tbl[i / 3]) begin
        errors++;
        $display("FAIL decode cyc %0d: fbit=%b want %b", i, fbit, onehot_tbl[i / 3]);
      end
      step();
    end
    checks++;
    if ({tbit, valid, busy, sweep_done} !== 5'b00_001) begin
      errors++;
      $display("FAIL oneshot end: tbit=%0d valid=%b busy=%b done=%b, want 0 0 0 1",
               tbit, valid, busy, sweep_done);
    end
    step();
    checks++;
    if (sweep_done !== 1'b0) begin
      errors++;
      $display("FAIL oneshot pulse width: done=%b want 0", sweep_done);
    end
    $display("oneshot: dwell 3 sweep complete");
  endtask

  task automatic test_continuous();
    logic [1:0] seq [6] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    mode = 1'b1; dwell = 8'd0; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 6; i++) begin
      logic exp_d;
      exp_d = (i == 4);
      checks++;
      if (tbit !== seq[i] || valid !== 1'b1 || sweep_done !== exp_d) begin
        errors++;
        $display("FAIL cont cyc %0d: tbit=%0d valid=%b done=%b, want %0d 1 %b",
                 i, tbit, valid, sweep_done, seq[i], exp_d);
      end
      if (i == 5) stop = 1'b1;
      step();
    end
    stop = 1'b0;
    checks++;
    if ({tbit, valid, busy, sweep_done} !== 5'b00_000) begin
      errors++;
      $display("FAIL cont stop: tbit=%0d valid=%b busy=%b done=%b, want 0 0 0 0",
               tbit, valid, busy, sweep_done);
    end
    step();
    checks++;
    if (sweep_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL cont after stop: done=%b busy=%b want 0 0", sweep_done, busy);
    end
    $display("continuous: wrap and stop done");
  endtask

  task automatic test_pause();
    logic [1:0] seq [12] = '{2'd0, 2'd0, 2'd1, 2'd1, 2'd2, 2'd2,
                             2'd2, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3};
    mode = 1'b0; dwell = 8'd2; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      checks++;
      if (tbit !== seq[i] || valid !== 1'b1) begin
        errors++;
        $display("FAIL pause cyc %0d: tbit=%0d valid=%b, want %0d 1", i, tbit, valid, seq[i]);
      end
      pause = (i >= 5 && i <= 8);
      step();
    end
    pause = 1'b0;
    checks++;
    if (valid !== 1'b0 || sweep_done !== 1'b1) begin
      errors++;
      $display("FAIL pause end: valid=%b done=%b want 0 1", valid, sweep_done);
    end
    step();
    $display("pause: hold on channel 2 done");
  endtask

  task automatic test_corners();
    start = 1'b1; stop = 1'b1; mode = 1'b0; dwell = 8'd1;
    step();
    start = 1'b0; stop = 1'b0;
    checks++;
    if (busy !== 1'b0 || valid !== 1'b0) begin
      errors++;
      $display("FAIL start_stop: busy=%b valid=%b want 0 0", busy, valid);
    end
    dwell = 8'd5; start = 1'b1;
    step();
    start = 1'b0; dwell = 8'd1;
    for (int i = 0; i < 7; i++) begin
      logic [1:0] exp_t;
      exp_t = 2'(i / 5);
      checks++;
      if (tbit !== exp_t || busy !== 1'b1) begin
        errors++;
        $display("FAIL dwell_keep cyc %0d: tbit=%0d busy=%b want %0d 1", i, tbit, busy, exp_t);
      end
      step();
    end
    rst_n = 1'b0;
    step();
    checks++;
    if ({tbit, valid, busy, sweep_done} !== 5'b00_000) begin
      errors++;
      $display("FAIL midrun reset: tbit=%0d valid=%b busy=%b done=%b want 0 0 0 0",
               tbit, valid, busy, sweep_done);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (sweep_done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL after reset: done=%b busy=%b want 0 0", sweep_done, busy);
    end
    $display("corners: start/stop, dwell latch, mid-run reset done");
  endtask

  initial begin
    test_reset();
    test_oneshot();
    test_continuous();
    test_pause();
    test_corners();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
